// File: rtl/prbs31_seq_ctrl_if.sv
// prbs31_seq_ctrl_if: control, generator and loopback signals of the PRBS31 sequencer
interface prbs31_seq_ctrl_if #(parameter int LEN_W = 16);
  logic start, abort, inject, gen_bit, gen_load, gen_en, tx_bit, rx_bit, rx_valid, busy, done, locked;
  logic [LEN_W-1:0] cfg_len, err_cnt, bit_cnt;
  logic [30:0] gen_seed;
  modport master(
    output start, abort, cfg_len, inject, gen_bit, rx_bit, rx_valid,
    input gen_load, gen_seed, gen_en, tx_bit, busy, done, locked, err_cnt, bit_cnt
  );
  modport slave(
    input start, abort, cfg_len, inject, gen_bit, rx_bit, rx_valid,
    output gen_load, gen_seed, gen_en, tx_bit, busy, done, locked, err_cnt, bit_cnt
  );
endinterface

// File: rtl/prbs31_seq_ctrl.sv
// prbs31_seq_ctrl: seeds/bursts a PRBS31 generator and checks the looped-back stream
module prbs31_seq_ctrl #(
  parameter logic [30:0] SEED = 31'h7FFF_FFFF,
  parameter int DRAIN_CYC = 4,
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic rst_n,
  prbs31_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] len_q, bit_cnt, err_cnt;
  logic [30:0] sh;
  logic [4:0] fill;
  logic [7:0] drain_cnt;
  logic locked, accept, last, chk, pred;
  always_comb begin
    accept = (state == IDLE || state == DONE) && bus.start && !bus.abort;
    last = len_q != '0 && bit_cnt == len_q - 1'b1;
    chk = (state == RUN || state == DRAIN) && bus.rx_valid && !bus.abort;
    pred = sh[30] ^ sh[27];
    nxt = state;
    if (bus.abort) nxt = IDLE;
    else
      case (state)
        IDLE, DONE: nxt = bus.start ? LOAD : state;
        LOAD: nxt = RUN;
        RUN: nxt = last ? DRAIN : RUN;
        DRAIN: nxt = drain_cnt == '0 ? DONE : DRAIN;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      bit_cnt <= '0;
      err_cnt <= '0;
      fill <= '0;
      sh <= '0;
      locked <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        len_q <= bus.cfg_len;
        bit_cnt <= '0;
        err_cnt <= '0;
        fill <= '0;
        sh <= '0;
        locked <= 1'b0;
      end
      if (!bus.abort && state == RUN) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (last) drain_cnt <= 8'(DRAIN_CYC - 1);
      end
      if (!bus.abort && state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      // comparisons start only once 31 history bits exist to predict from
      if (chk) begin
        sh <= {sh[29:0], bus.rx_bit};
        if (!locked) begin
          fill <= fill + 1'b1;
          locked <= fill == 5'd30;
        end else if (bus.rx_bit != pred && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
  assign bus.gen_load = state == LOAD;
  assign bus.gen_en = state == RUN;
  assign bus.busy = state == LOAD || state == RUN || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.gen_seed = SEED;
  assign bus.tx_bit = bus.gen_bit ^ (bus.inject & (state == RUN));
  assign bus.locked = locked;
  assign bus.err_cnt = err_cnt;
  assign bus.bit_cnt = bit_cnt;
endmodule

// File: tb/tb_prbs31_seq_ctrl.sv
// tb_prbs31_seq_ctrl: randomized scenario tests against a stream-level reference model
module tb_prbs31_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic inv = 1'b0, vrand = 1'b0, rv = 1'b0;
  logic [30:0] g = '0;
  int checks = 0, failures = 0;
  bit rxq[$];
  prbs31_seq_ctrl_if #(.LEN_W(16)) bus();
  prbs31_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // generator core stand-in: s[30] out, feedback x^31 + x^28 + 1
  always @(posedge clk)
    if (bus.gen_load) g <= bus.gen_seed;
    else if (bus.gen_en) g <= {g[29:0], g[30] ^ g[27]};
  assign bus.gen_bit = g[30];
  assign bus.rx_bit = bus.tx_bit ^ inv;
  assign bus.rx_valid = vrand ? rv : bus.gen_en;

  function automatic int model_errs();
    int e = 0;
    for (int i = 31; i < rxq.size(); i++) if (rxq[i] != (rxq[i-31] ^ rxq[i-28])) e++;
    return e > 65535 ? 65535 : e;
  endfunction

  // accept edge is edge 0; iteration j observes the state sampled at edge j
  task automatic run_burst(input int len, input int inj, input bit rvmode,
                           output int n_load, output int n_en, output int done_at);
    rxq.delete();
    n_load = 0; n_en = 0; done_at = -1;
    vrand = rvmode;
    bus.cfg_len = 16'(len); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cfg_len = 16'($urandom);
    for (int j = 1; j <= len + 6; j++) begin
      rv = rvmode ? ($urandom_range(0, 3) != 0) : 1'b0;
      bus.inject = inj >= 0 && j == inj + 2;
      #1;
      if (bus.gen_load) n_load++;
      if (bus.gen_en) n_en++;
      if (bus.done && done_at < 0) done_at = j;
      if (bus.rx_valid && j >= 2 && j <= len + 5) rxq.push_back(bus.rx_bit);
      @(negedge clk);
    end
    bus.inject = 1'b0; rv = 1'b0; vrand = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.gen_load, bus.gen_en, bus.busy, bus.done, bus.locked} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.gen_load, bus.gen_en, bus.busy, bus.done, bus.locked}); end
    checks++; if (bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got err=%0d bit=%0d exp=0,0", bus.err_cnt, bus.bit_cnt); end
    checks++; if (bus.gen_seed !== 31'h7FFF_FFFF) begin failures++; $display("FAIL reset_seed got=%h exp=7fffffff", bus.gen_seed); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int nl, ne, da;
    run_burst(100, -1, 1'b0, nl, ne, da);
    checks++; if (nl !== 1) begin failures++; $display("FAIL basic_load_cycles got=%0d exp=1", nl); end
    checks++; if (ne !== 100) begin failures++; $display("FAIL basic_en_cycles got=%0d exp=100", ne); end
    checks++; if (da !== 106) begin failures++; $display("FAIL basic_done_time got=%0d exp=106", da); end
    checks++; if (bus.bit_cnt !== 16'd100) begin failures++; $display("FAIL basic_bit_cnt got=%0d exp=100", bus.bit_cnt); end
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL basic_locked got=%b exp=1", bus.locked); end
    checks++; if (bus.err_cnt !== 16'd0 || model_errs() != 0) begin failures++; $display("FAIL basic_err got=%0d model=%0d exp=0", bus.err_cnt, model_errs()); end
  endtask

  task automatic test_inject();
    int nl, ne, da;
    run_burst(100, 40, 1'b0, nl, ne, da);
    checks++; if (bus.err_cnt !== 16'(model_errs()) || bus.err_cnt !== 16'd3) begin failures++; $display("FAIL inject_err got=%0d model=%0d exp=3", bus.err_cnt, model_errs()); end
    checks++; if (bus.done !== 1'b1 || da !== 106) begin failures++; $display("FAIL inject_done got=%b at=%0d exp=1 at=106", bus.done, da); end
  endtask

  task automatic test_random();
    int nl, ne, da, len, inj;
    for (int t = 0; t < 6; t++) begin
      len = t == 0 ? 1 : int'($urandom_range(2, 300));
      inj = $urandom_range(0, 1) ? int'($urandom_range(0, len - 1)) : -1;
      run_burst(len, inj, 1'b1, nl, ne, da);
      checks++; if (ne !== len || da !== len + 6) begin failures++; $display("FAIL rand_timing len=%0d got en=%0d done_at=%0d exp en=%0d done_at=%0d", len, ne, da, len, len + 6); end
      checks++; if (bus.bit_cnt !== 16'(len)) begin failures++; $display("FAIL rand_bit_cnt got=%0d exp=%0d", bus.bit_cnt, len); end
      checks++; if (bus.err_cnt !== 16'(model_errs())) begin failures++; $display("FAIL rand_err len=%0d inj=%0d got=%0d exp=%0d", len, inj, bus.err_cnt, model_errs()); end
      checks++; if (bus.locked !== (rxq.size() >= 31)) begin failures++; $display("FAIL rand_locked got=%b exp=%b", bus.locked, rxq.size() >= 31); end
    end
  endtask

  task automatic test_start_abort();
    logic [15:0] held;
    held = bus.bit_cnt;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bit_cnt !== held) begin failures++; $display("FAIL abort_from_done got done=%b busy=%b bit=%0d exp 0,0,%0d", bus.done, bus.busy, bus.bit_cnt, held); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.gen_load !== 1'b0) begin failures++; $display("FAIL start_abort_idle got busy=%b load=%b exp=0,0", bus.busy, bus.gen_load); end
    bus.abort = 1'b0; bus.cfg_len = 16'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (21) @(negedge clk);
    checks++; if (bus.bit_cnt !== 16'd20) begin failures++; $display("FAIL run_count got=%0d exp=20", bus.bit_cnt); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.gen_load !== 1'b0 || bus.bit_cnt !== 16'd21) begin failures++; $display("FAIL start_in_run got load=%b bit=%0d exp=0,21", bus.gen_load, bus.bit_cnt); end
    repeat (9) @(negedge clk);
    checks++; if (bus.bit_cnt !== 16'd30 || bus.gen_en !== 1'b1) begin failures++; $display("FAIL run_continues got bit=%0d en=%b exp=30,1", bus.bit_cnt, bus.gen_en); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.gen_en !== 1'b0 || bus.bit_cnt !== 16'd30) begin failures++; $display("FAIL abort_run got busy=%b en=%b bit=%0d exp=0,0,30", bus.busy, bus.gen_en, bus.bit_cnt); end
  endtask

  task automatic test_saturate_wrap();
    inv = 1'b1;
    bus.cfg_len = 16'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    repeat (70000) @(negedge clk);
    checks++; if (bus.bit_cnt !== 16'd4464) begin failures++; $display("FAIL wrap_bit_cnt got=%0d exp=4464", bus.bit_cnt); end
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL wrap_state got busy=%b done=%b exp=1,0", bus.busy, bus.done); end
    checks++; if (bus.err_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_err got=%h exp=ffff", bus.err_cnt); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.gen_en !== 1'b0 || bus.busy !== 1'b0 || bus.err_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_abort got en=%b busy=%b err=%h exp=0,0,ffff", bus.gen_en, bus.busy, bus.err_cnt); end
    inv = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int nl, ne, da;
    bus.cfg_len = 16'd150; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({bus.gen_load, bus.gen_en, bus.busy, bus.done, bus.locked} !== 5'b0 || bus.bit_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset got flags=%b bit=%0d err=%0d exp all 0", {bus.gen_load, bus.gen_en, bus.busy, bus.done, bus.locked}, bus.bit_cnt, bus.err_cnt); end
    run_burst(64, -1, 1'b0, nl, ne, da);
    checks++; if (bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd64 || da !== 70) begin failures++; $display("FAIL post_reset_run got err=%0d bit=%0d done_at=%0d exp=0,64,70", bus.err_cnt, bus.bit_cnt, da); end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.inject = 1'b0; bus.cfg_len = '0;
    test_reset();
    test_basic();
    test_inject();
    test_random();
    test_start_abort();
    test_saturate_wrap();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prbs31_seq_ctrl.md
Name: prbs31_seq_ctrl

Overview:
Test sequencer and checker for the PRBS31 generator (x^31 + x^28 + 1) in the tt_um_Parikshith2901_prbs31 top.
- Seeds the generator, enables it for a programmed burst length, and can invert one transmitted bit on demand.
- Checks the looped-back stream with a self-synchronising checker and reports lock, error count and completion.
- Sits between the ui_in/uo_out pin logic and the generator core.

Parameters:
SEED, 31'h7FFF_FFFF, value driven on gen_seed during LOAD; must be nonzero.
DRAIN_CYC, 4, cycles the checker keeps accepting rx bits after the last tx bit (range 1..255).
LEN_W, 16, width of cfg_len, bit_cnt and err_cnt.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a test; honoured only in IDLE or DONE
abort  in  1  return to IDLE from any state
cfg_len  in  LEN_W  burst length in bits, latched on accepted start; 0 = continuous
inject  in  1  invert tx_bit in this cycle (RUN only)
gen_bit  in  1  generator output bit
gen_load  out  1  load gen_seed into generator
gen_seed  out  31  seed value (= SEED)
gen_en  out  1  advance generator one bit
tx_bit  out  1  transmitted bit = gen_bit ^ (inject & RUN)
rx_bit  in  1  looped-back received bit
rx_valid  in  1  rx_bit valid this cycle
busy  out  1  state is LOAD, RUN or DRAIN
done  out  1  state is DONE
locked  out  1  checker has received 31 bits
err_cnt  out  LEN_W  saturating error count
bit_cnt  out  LEN_W  tx bits sent in the current test

Behaviour:
Reset (rst_n=0 at an edge):
- state=IDLE; len_q=0; bit_cnt=0; err_cnt=0; fill=0; sh=0; locked=0; drain_cnt=0.
- Outputs: gen_load=0, gen_en=0, busy=0, done=0.
- Reset mid-test discards the test entirely.

States: IDLE, LOAD, RUN, DRAIN, DONE. gen_load, gen_en, busy and done are decoded from the registered state.
- IDLE/DONE: start=1 and abort=0 -> LOAD. On that edge: len_q<=cfg_len; bit_cnt, err_cnt, fill, locked, sh all cleared.
- LOAD (exactly 1 cycle): gen_load=1, gen_en=0 -> RUN.
- RUN: gen_en=1; bit_cnt+=1 every cycle.
  - len_q!=0 and bit_cnt==len_q-1 -> DRAIN with drain_cnt<=DRAIN_CYC-1.
  - len_q==0: stays in RUN; bit_cnt wraps modulo 2^LEN_W.
- DRAIN: gen_en=0; drain_cnt decrements; at 0 -> DONE.
- DONE: done=1; err_cnt, bit_cnt and locked hold until the next accepted start.
- abort=1 in any state -> IDLE next cycle; counters hold their values; abort has priority over start.
- start while busy is ignored.

Checker (active in RUN and DRAIN when rx_valid=1):
- sh <= {sh[29:0], rx_bit}; sh[0] is the newest bit.
- pred = sh[30] ^ sh[27], evaluated before the shift.
- While fill<31: fill+=1; no comparisons are made. locked=1 once fill==31.
- When locked: rx_bit!=pred -> err_cnt+=1, saturating at all-ones.
- rx_valid is ignored in IDLE, LOAD and DONE.

Error signature: one flipped bit at stream index n (n>=31) produces exactly 3 errors, at n, n+28 and n+31.

Timing: start accepted at edge k -> LOAD in cycle k+1 -> RUN cycles k+2..k+1+L -> done=1 from cycle k+2+L+DRAIN_CYC.

tx_bit is combinational from gen_bit and inject; no added latency.

Test Plan:
1. cfg_len=100, loopback rx_bit=tx_bit, rx_valid=gen_en, pulse start -> gen_load for 1 cycle, 100 gen_en cycles, done 105 cycles after LOAD; bit_cnt=100, locked=1, err_cnt=0.
2. Same as 1, with inject pulsed on RUN bit index 40 -> err_cnt=3 at DONE.
3. rx_bit=~tx_bit, cfg_len=0, run 70000 cycles then abort -> err_cnt=16'hFFFF (saturated), state IDLE, gen_en=0 the cycle after abort.
4. cfg_len=0, run 70000 cycles -> bit_cnt wraps to 70000-65536=4464; still busy, done=0.
5. start and abort high together in IDLE -> remains IDLE; start pulsed during RUN -> ignored, bit_cnt continues without clearing.
6. rst_n=0 for 1 cycle mid-RUN -> next cycle all outputs at reset values; a following start runs a clean test with err_cnt=0.
